// File: rtl/rr_ex_pipeline_reg.sv
// RR->EX pipeline register with stall/flush control and write-back snoop capture.
// Define RR_EX_BUBBLE_CNT_EN to add a saturating 16-bit bubble counter output.
module rr_ex_pipeline_reg #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_rr,
    input  logic [DATA_W-1:0] pc_rr,
    input  logic [3:0]        opcode_rr,
    input  logic [ADDR_W-1:0] rs1_addr_rr,
    input  logic [ADDR_W-1:0] rs2_addr_rr,
    input  logic [ADDR_W-1:0] rd_addr_rr,
    input  logic              reg_wr_en_rr,
    input  logic [DATA_W-1:0] rs1_data_rr,
    input  logic [DATA_W-1:0] rs2_data_rr,
    input  logic [DATA_W-1:0] imm_rr,
    input  logic [ADDR_W-1:0] wb_rd_addr,
    input  logic              wb_reg_wr_en,
    input  logic [DATA_W-1:0] wb_data,
    output logic              valid_rr_ex,
    output logic [DATA_W-1:0] pc_rr_ex,
    output logic [3:0]        opcode_rr_ex,
    output logic [ADDR_W-1:0] rs1_addr_rr_ex,
    output logic [ADDR_W-1:0] rs2_addr_rr_ex,
    output logic [ADDR_W-1:0] rd_addr_rr_ex,
    output logic              reg_wr_en_rr_ex,
    output logic [DATA_W-1:0] rs1_data_rr_ex,
    output logic [DATA_W-1:0] rs2_data_rr_ex,
    output logic [DATA_W-1:0] imm_rr_ex,
    output logic [ADDR_W-1:0] rd_prev_addr_rr_ex,
    output logic              reg_wr_en_rr_ex_prev,
    output logic [DATA_W-1:0] rd_prev_data_rr_ex
`ifdef RR_EX_BUBBLE_CNT_EN
    ,
    output logic [15:0]       bubble_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [ADDR_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [ADDR_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              reg_wr_en_q, reg_wr_en_d;
    logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
    logic              prev_wr_en_q, prev_wr_en_d;
    logic [DATA_W-1:0] prev_data_q, prev_data_d;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so the stall path holds state and no latch is inferred.
        state_d      = state_q;
        pc_d         = pc_q;
        opcode_d     = opcode_q;
        rs1_addr_d   = rs1_addr_q;
        rs2_addr_d   = rs2_addr_q;
        rd_addr_d    = rd_addr_q;
        reg_wr_en_d  = reg_wr_en_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        imm_d        = imm_q;
        prev_addr_d  = prev_addr_q;
        prev_wr_en_d = prev_wr_en_q;
        prev_data_d  = prev_data_q;

        if (flush) begin
            state_d      = EMPTY;
            pc_d         = '0;
            opcode_d     = '0;
            rs1_addr_d   = '0;
            rs2_addr_d   = '0;
            rd_addr_d    = '0;
            reg_wr_en_d  = 1'b0;
            rs1_data_d   = '0;
            rs2_data_d   = '0;
            imm_d        = '0;
            prev_addr_d  = '0;
            prev_wr_en_d = 1'b0;
            prev_data_d  = '0;
        end else if (!stall) begin
            state_d      = valid_rr ? FULL : EMPTY;
            pc_d         = pc_rr;
            opcode_d     = opcode_rr;
            rs1_addr_d   = rs1_addr_rr;
            rs2_addr_d   = rs2_addr_rr;
            rd_addr_d    = rd_addr_rr;
            // An invalid slot must never request a register write.
            reg_wr_en_d  = reg_wr_en_rr & valid_rr;
            rs1_data_d   = rs1_data_rr;
            rs2_data_d   = rs2_data_rr;
            imm_d        = imm_rr;
            prev_addr_d  = wb_rd_addr;
            prev_wr_en_d = wb_reg_wr_en;
            prev_data_d  = wb_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            pc_q         <= '0;
            opcode_q     <= '0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rd_addr_q    <= '0;
            reg_wr_en_q  <= 1'b0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            prev_addr_q  <= '0;
            prev_wr_en_q <= 1'b0;
            prev_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            opcode_q     <= opcode_d;
            rs1_addr_q   <= rs1_addr_d;
            rs2_addr_q   <= rs2_addr_d;
            rd_addr_q    <= rd_addr_d;
            reg_wr_en_q  <= reg_wr_en_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            prev_addr_q  <= prev_addr_d;
            prev_wr_en_q <= prev_wr_en_d;
            prev_data_q  <= prev_data_d;
        end
    end

    assign valid_rr_ex          = (state_q == FULL);
    assign pc_rr_ex             = pc_q;
    assign opcode_rr_ex         = opcode_q;
    assign rs1_addr_rr_ex       = rs1_addr_q;
    assign rs2_addr_rr_ex       = rs2_addr_q;
    assign rd_addr_rr_ex        = rd_addr_q;
    assign reg_wr_en_rr_ex      = reg_wr_en_q;
    assign rs1_data_rr_ex       = rs1_data_q;
    assign rs2_data_rr_ex       = rs2_data_q;
    assign imm_rr_ex            = imm_q;
    assign rd_prev_addr_rr_ex   = prev_addr_q;
    assign reg_wr_en_rr_ex_prev = prev_wr_en_q;
    assign rd_prev_data_rr_ex   = prev_data_q;

`ifdef RR_EX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    // A bubble is any edge that leaves the slot empty through flush or an invalid load.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if ((flush || (!stall && !valid_rr)) && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_rr_ex_pipeline_reg.sv
// Self-checking bench for rr_ex_pipeline_reg: directed scenarios plus a randomized run
// against a slot-level reference model. Build with RR_EX_BUBBLE_CNT_EN to also check bubble_cnt.
module tb_rr_ex_pipeline_reg;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, flush;
    logic          valid_rr;
    logic [DW-1:0] pc_rr;
    logic [3:0]    opcode_rr;
    logic [AW-1:0] rs1_addr_rr, rs2_addr_rr, rd_addr_rr;
    logic          reg_wr_en_rr;
    logic [DW-1:0] rs1_data_rr, rs2_data_rr, imm_rr;
    logic [AW-1:0] wb_rd_addr;
    logic          wb_reg_wr_en;
    logic [DW-1:0] wb_data;

    logic          valid_rr_ex;
    logic [DW-1:0] pc_rr_ex;
    logic [3:0]    opcode_rr_ex;
    logic [AW-1:0] rs1_addr_rr_ex, rs2_addr_rr_ex, rd_addr_rr_ex;
    logic          reg_wr_en_rr_ex;
    logic [DW-1:0] rs1_data_rr_ex, rs2_data_rr_ex, imm_rr_ex;
    logic [AW-1:0] rd_prev_addr_rr_ex;
    logic          reg_wr_en_rr_ex_prev;
    logic [DW-1:0] rd_prev_data_rr_ex;
`ifdef RR_EX_BUBBLE_CNT_EN
    logic [15:0]   bubble_cnt;
`endif

    always #5 clk = ~clk;

    rr_ex_pipeline_reg #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .stall                (stall),
        .flush                (flush),
        .valid_rr             (valid_rr),
        .pc_rr                (pc_rr),
        .opcode_rr            (opcode_rr),
        .rs1_addr_rr          (rs1_addr_rr),
        .rs2_addr_rr          (rs2_addr_rr),
        .rd_addr_rr           (rd_addr_rr),
        .reg_wr_en_rr         (reg_wr_en_rr),
        .rs1_data_rr          (rs1_data_rr),
        .rs2_data_rr          (rs2_data_rr),
        .imm_rr               (imm_rr),
        .wb_rd_addr           (wb_rd_addr),
        .wb_reg_wr_en         (wb_reg_wr_en),
        .wb_data              (wb_data),
        .valid_rr_ex          (valid_rr_ex),
        .pc_rr_ex             (pc_rr_ex),
        .opcode_rr_ex         (opcode_rr_ex),
        .rs1_addr_rr_ex       (rs1_addr_rr_ex),
        .rs2_addr_rr_ex       (rs2_addr_rr_ex),
        .rd_addr_rr_ex        (rd_addr_rr_ex),
        .reg_wr_en_rr_ex      (reg_wr_en_rr_ex),
        .rs1_data_rr_ex       (rs1_data_rr_ex),
        .rs2_data_rr_ex       (rs2_data_rr_ex),
        .imm_rr_ex            (imm_rr_ex),
        .rd_prev_addr_rr_ex   (rd_prev_addr_rr_ex),
        .reg_wr_en_rr_ex_prev (reg_wr_en_rr_ex_prev),
        .rd_prev_data_rr_ex   (rd_prev_data_rr_ex)
`ifdef RR_EX_BUBBLE_CNT_EN
        ,
        .bubble_cnt           (bubble_cnt)
`endif
    );

    // Reference model: the instruction record currently held in the EX slot.
    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [3:0]    opcode;
        logic [AW-1:0] rs1, rs2, rd;
        logic          wen;
        logic [DW-1:0] d1, d2, imm;
        logic [AW-1:0] prev_addr;
        logic          prev_wen;
        logic [DW-1:0] prev_data;
    } slot_t;

    slot_t slot;
    int    bubbles;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".valid"},     32'(valid_rr_ex),          32'(slot.valid));
        check({ctx, ".pc"},        32'(pc_rr_ex),             32'(slot.pc));
        check({ctx, ".opcode"},    32'(opcode_rr_ex),         32'(slot.opcode));
        check({ctx, ".rs1_addr"},  32'(rs1_addr_rr_ex),       32'(slot.rs1));
        check({ctx, ".rs2_addr"},  32'(rs2_addr_rr_ex),       32'(slot.rs2));
        check({ctx, ".rd_addr"},   32'(rd_addr_rr_ex),        32'(slot.rd));
        check({ctx, ".wen"},       32'(reg_wr_en_rr_ex),      32'(slot.wen));
        check({ctx, ".rs1_data"},  32'(rs1_data_rr_ex),       32'(slot.d1));
        check({ctx, ".rs2_data"},  32'(rs2_data_rr_ex),       32'(slot.d2));
        check({ctx, ".imm"},       32'(imm_rr_ex),            32'(slot.imm));
        check({ctx, ".prev_addr"}, 32'(rd_prev_addr_rr_ex),   32'(slot.prev_addr));
        check({ctx, ".prev_wen"},  32'(reg_wr_en_rr_ex_prev), 32'(slot.prev_wen));
        check({ctx, ".prev_data"}, 32'(rd_prev_data_rr_ex),   32'(slot.prev_data));
`ifdef RR_EX_BUBBLE_CNT_EN
        check({ctx, ".bubble_cnt"}, 32'(bubble_cnt),          32'(bubbles));
`endif
    endtask

    task automatic model_reset();
        slot    = '0;
        bubbles = 0;
    endtask

    // What the EX slot should hold after the coming edge, given the current inputs.
    task automatic model_edge();
        if (flush) begin
            slot = '0;
            if (bubbles < 65535) bubbles++;
        end else if (!stall) begin
            slot.valid     = valid_rr;
            slot.pc        = pc_rr;
            slot.opcode    = opcode_rr;
            slot.rs1       = rs1_addr_rr;
            slot.rs2       = rs2_addr_rr;
            slot.rd        = rd_addr_rr;
            slot.wen       = valid_rr && reg_wr_en_rr;
            slot.d1        = rs1_data_rr;
            slot.d2        = rs2_data_rr;
            slot.imm       = imm_rr;
            slot.prev_addr = wb_rd_addr;
            slot.prev_wen  = wb_reg_wr_en;
            slot.prev_data = wb_data;
            if (!valid_rr && bubbles < 65535) bubbles++;
        end
    endtask

    task automatic rand_inputs();
        valid_rr     = 1'($urandom);
        pc_rr        = DW'($urandom);
        opcode_rr    = 4'($urandom);
        rs1_addr_rr  = AW'($urandom);
        rs2_addr_rr  = AW'($urandom);
        rd_addr_rr   = AW'($urandom);
        reg_wr_en_rr = 1'($urandom);
        rs1_data_rr  = DW'($urandom);
        rs2_data_rr  = DW'($urandom);
        imm_rr       = DW'($urandom);
        wb_rd_addr   = AW'($urandom);
        wb_reg_wr_en = 1'($urandom);
        wb_data      = DW'($urandom);
    endtask

    task automatic step(input string ctx);
        model_edge();
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        rand_inputs();
        model_reset();

        // Reset holds every output at zero across clock edges.
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");

        // Reset-release load.
        valid_rr     = 1'b1;
        rd_addr_rr   = 3'd5;
        reg_wr_en_rr = 1'b1;
        rs1_data_rr  = 16'h1234;
        @(negedge clk);
        rst_n = 1'b1;
        step("release_load");
        check("release_load.rd_is_5",    32'(rd_addr_rr_ex),  32'd5);
        check("release_load.rs1_1234",   32'(rs1_data_rr_ex), 32'h1234);

        // Stall hold for three cycles, then load the waiting instruction.
        rand_inputs();
        valid_rr = 1'b1;
        pc_rr    = 16'h0010;
        step("stall_pre");
        stall = 1'b1;
        pc_rr = 16'h0012;
        for (int i = 0; i < 3; i++) begin
            step("stall_hold");
            check("stall_hold.pc_0010", 32'(pc_rr_ex), 32'h0010);
        end
        stall = 1'b0;
        step("stall_release");
        check("stall_release.pc_0012", 32'(pc_rr_ex), 32'h0012);

        // Snoop capture on a load edge, preserved through a stall.
        rand_inputs();
        wb_rd_addr   = 3'd2;
        wb_reg_wr_en = 1'b1;
        wb_data      = 16'hBEEF;
        step("snoop_load");
        check("snoop_load.prev_data", 32'(rd_prev_data_rr_ex), 32'hBEEF);
        stall   = 1'b1;
        wb_data = 16'h0000;
        step("snoop_stall");
        check("snoop_stall.prev_data", 32'(rd_prev_data_rr_ex), 32'hBEEF);
        stall = 1'b0;

        // Flush overrides stall with a full slot.
        rand_inputs();
        valid_rr     = 1'b1;
        reg_wr_en_rr = 1'b1;
        wb_reg_wr_en = 1'b1;
        step("flush_pre");
        stall = 1'b1;
        flush = 1'b1;
        step("flush_over_stall");
        check("flush_over_stall.valid", 32'(valid_rr_ex), 32'd0);
        stall = 1'b0;
        flush = 1'b0;

        // Write-enable masking on an invalid slot, which also counts as a bubble.
        rand_inputs();
        valid_rr     = 1'b1;
        reg_wr_en_rr = 1'b1;
        step("mask_pre");
        valid_rr = 1'b0;
        step("mask_invalid");
        check("mask_invalid.wen", 32'(reg_wr_en_rr_ex), 32'd0);

        // Randomized traffic with occasional stall and flush.
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            step("random");
        end
        stall = 1'b0;
        flush = 1'b0;

        // Asynchronous reset mid-cycle with a full slot and a pending stall.
        rand_inputs();
        valid_rr = 1'b1;
        step("async_pre");
        stall = 1'b1;
        rand_inputs();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("async_reset_hold");

        // First edge after release behaves as a normal load.
        stall    = 1'b0;
        valid_rr = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset_load");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
